// File: rtl/fp_encode_seq_if.sv
// Handshake bus for fp_encode_seq: sample in, sign/exponent/significand out.
interface fp_encode_seq_if #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  din;
  logic             out_valid;
  logic             out_ready;
  logic             sign;
  logic [EXP_W-1:0] exp;
  logic [SIG_W-1:0] sig;

  // Producer/consumer side (testbench or surrounding logic)
  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, sign, exp, sig
  );

  // Encoder side
  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, sign, exp, sig
  );
endinterface

// File: rtl/fp_encode_seq.sv
// Multi-cycle linear-to-floating-point encoder.
// Value = (-1)^sign * sig * 2^exp. The exponent is walked down one step per clock
// from EMAX until the significand MSB is set, then the result is rounded.
// Optional build macro: ROUND_NEAREST_EVEN_EN selects round-to-nearest-even;
// without it rounding is half-up.
module fp_encode_seq #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input logic          clk,
  input logic          rst,
  fp_encode_seq_if.slave bus
);
  localparam int MW   = IN_W - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int SATB = EMAX + SIG_W;
  localparam logic [EXP_W-1:0] EMAX_E = '1;
  localparam logic [EXP_W-1:0] E_ONE  = 1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
  state_t state, state_nxt;

  logic             s_q;
  logic [MW-1:0]    m;
  logic [EXP_W-1:0] e;
  logic             sat_q;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [SIG_W-1:0] sig_q;
  logic             vld_q;

  logic [MW-1:0]    m_in;
  logic             sat_in;
  logic [SIG_W-1:0] f;
  logic             top;
  logic             r;
  logic             inc;
  logic [SIG_W:0]   fr;
  logic [EXP_W-1:0] e_res;
  logic [SIG_W-1:0] f_res;
  logic             norm_done;
`ifdef ROUND_NEAREST_EVEN_EN
  logic             t;
`endif

  // Magnitude of the incoming sample; most-negative value clamps to max magnitude
  always_comb begin
    if (bus.din == {1'b1, {MW{1'b0}}})
      m_in = '1;
    else if (bus.din[IN_W-1])
      m_in = MW'(-bus.din);
    else
      m_in = bus.din[MW-1:0];
    // Magnitudes beyond the largest representable exponent force saturation
    sat_in = |(m_in >> SATB);
  end

  // Significand window at the current exponent, round bit and rounded result
  always_comb begin
    f         = SIG_W'(m >> e);
    top       = f[SIG_W-1];
    norm_done = (e == '0) || top;
    r         = (e == '0) ? 1'b0 : 1'(m >> (e - E_ONE));
`ifdef ROUND_NEAREST_EVEN_EN
    t         = (e > E_ONE) ? |(m & ((MW'(1) << (e - E_ONE)) - MW'(1))) : 1'b0;
    inc       = r & (t | f[0]);
`else
    inc       = r;
`endif
    fr        = {1'b0, f} + {{SIG_W{1'b0}}, inc};
    if (sat_q || (fr[SIG_W] && e == EMAX_E)) begin
      e_res = EMAX_E;
      f_res = '1;
    end else if (fr[SIG_W]) begin
      // Carry out of the significand: renormalise one exponent step up
      e_res = e + E_ONE;
      f_res = {1'b1, {(SIG_W-1){1'b0}}};
    end else begin
      e_res = e;
      f_res = fr[SIG_W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = NORM;
      NORM:    if (norm_done)    state_nxt = ROUND;
      ROUND:                     state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Working registers and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 1'b0;
      m      <= '0;
      e      <= '0;
      sat_q  <= 1'b0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      sig_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          s_q   <= bus.din[IN_W-1];
          m     <= m_in;
          e     <= EMAX_E;
          sat_q <= sat_in;
        end
        NORM: if (!norm_done) e <= e - E_ONE;
        ROUND: begin
          sign_q <= s_q;
          exp_q  <= e_res;
          sig_q  <= f_res;
          vld_q  <= 1'b1;
        end
        OUT: if (bus.out_ready) vld_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = vld_q;
  assign bus.sign      = sign_q;
  assign bus.exp       = exp_q;
  assign bus.sig       = sig_q;
endmodule
